// File: rtl/branch_target_buffer.sv
// Fully associative branch target buffer. Fetch looks it up combinationally each cycle;
// execute trains it with resolved branches and allocates taken branches that missed.
module branch_target_buffer #(
  parameter int          XLEN        = 32,
  parameter int          NUM_ENTRIES = 4,
  parameter logic [1:0]  CTR_INIT    = 2'b10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] lookup_pc_in,
  output logic            hit_out,
  output logic            predict_taken_out,
  output logic [XLEN-1:0] predict_target_out,
  input  logic            update_valid_in,
  input  logic [XLEN-1:0] update_pc_in,
  input  logic            update_taken_in,
  input  logic [XLEN-1:0] update_target_in,
  input  logic            flush_in
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int TAG_W = XLEN - 2;

  logic [NUM_ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]       r_tag    [NUM_ENTRIES];
  logic [XLEN-1:0]        r_target [NUM_ENTRIES];
  logic [1:0]             r_ctr    [NUM_ENTRIES];
  logic [IDX_W-1:0]       r_ptr;

  logic [TAG_W-1:0] w_lk_tag;
  logic [TAG_W-1:0] w_up_tag;
  logic             w_lk_hit;
  logic [IDX_W-1:0] w_lk_idx;
  logic             w_up_hit;
  logic [IDX_W-1:0] w_up_idx;
  logic             w_free_any;
  logic [IDX_W-1:0] w_free_idx;
  logic [IDX_W-1:0] w_alloc_idx;
  logic             w_upd;
  logic             w_do_alloc;
  logic             w_unused_bits;

  // Instructions are word aligned, so the low PC bits never take part in the tag.
  assign w_lk_tag      = lookup_pc_in[XLEN-1:2];
  assign w_up_tag      = update_pc_in[XLEN-1:2];
  assign w_unused_bits = ^{lookup_pc_in[1:0], update_pc_in[1:0]};

  // Downward scans so that the lowest matching index wins.
  always_comb begin
    w_lk_hit = 1'b0;
    w_lk_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_tag[i] == w_lk_tag)) begin
        w_lk_hit = 1'b1;
        w_lk_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_up_hit = 1'b0;
    w_up_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_tag[i] == w_up_tag)) begin
        w_up_hit = 1'b1;
        w_up_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_free_any = 1'b0;
    w_free_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_any = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  assign w_alloc_idx = w_free_any ? w_free_idx : r_ptr;
  assign w_upd       = update_valid_in & ~flush_in;
  assign w_do_alloc  = w_upd & ~w_up_hit & update_taken_in;

  assign hit_out            = w_lk_hit;
  assign predict_taken_out  = w_lk_hit & r_ctr[w_lk_idx][1];
  assign predict_target_out = w_lk_hit ? r_target[w_lk_idx] : '0;

  // Valid bits and the round-robin pointer; the pointer only moves when a valid entry is evicted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_ptr   <= '0;
    end else if (flush_in) begin
      r_valid <= '0;
      r_ptr   <= '0;
    end else if (w_do_alloc) begin
      r_valid[w_alloc_idx] <= 1'b1;
      if (!w_free_any) begin
        r_ptr <= r_ptr + IDX_W'(1);
      end
    end
  end

  // Entry payload needs no reset: it is only observed through a valid bit.
  always_ff @(posedge clk) begin
    if (!reset && w_upd) begin
      if (w_up_hit) begin
        if (update_taken_in) begin
          r_ctr[w_up_idx]    <= (r_ctr[w_up_idx] == 2'b11) ? 2'b11 : r_ctr[w_up_idx] + 2'b01;
          r_target[w_up_idx] <= update_target_in;
        end else begin
          r_ctr[w_up_idx]    <= (r_ctr[w_up_idx] == 2'b00) ? 2'b00 : r_ctr[w_up_idx] - 2'b01;
        end
      end else if (update_taken_in) begin
        r_tag[w_alloc_idx]    <= w_up_tag;
        r_target[w_alloc_idx] <= update_target_in;
        r_ctr[w_alloc_idx]    <= CTR_INIT;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench: the driver predicts each cycle's lookup from a slot-table model and
// queues it; a negedge monitor pops and compares against the DUT outputs.
module tb_branch_target_buffer;
  localparam int XLEN = 32;
  localparam int N    = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [XLEN-1:0] lookup_pc_in;
  logic            hit_out;
  logic            predict_taken_out;
  logic [XLEN-1:0] predict_target_out;
  logic            update_valid_in;
  logic [XLEN-1:0] update_pc_in;
  logic            update_taken_in;
  logic [XLEN-1:0] update_target_in;
  logic            flush_in;

  always #5 clk = ~clk;

  branch_target_buffer #(.XLEN(XLEN), .NUM_ENTRIES(N), .CTR_INIT(2'b10)) dut (
    .clk                (clk),
    .reset              (reset),
    .lookup_pc_in       (lookup_pc_in),
    .hit_out            (hit_out),
    .predict_taken_out  (predict_taken_out),
    .predict_target_out (predict_target_out),
    .update_valid_in    (update_valid_in),
    .update_pc_in       (update_pc_in),
    .update_taken_in    (update_taken_in),
    .update_target_in   (update_target_in),
    .flush_in           (flush_in)
  );

  typedef struct packed {
    logic        hit;
    logic        taken;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic [15:0] step;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   started = 1'b0;
  int   step = 0;

  // Reference model: slots in index order, plus the round-robin pointer.
  bit          m_valid[N];
  logic [29:0] m_tag[N];
  logic [31:0] m_tgt[N];
  int          m_ctr[N];
  int          m_ptr;

  function automatic int m_find(input logic [31:0] pc);
    for (int i = 0; i < N; i++)
      if (m_valid[i] && m_tag[i] == pc[31:2]) return i;
    return -1;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    m_ptr = 0;
  endfunction

  function automatic void m_update(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
    int idx;
    int slot;
    idx = m_find(pc);
    if (idx >= 0) begin
      if (tk) begin
        m_ctr[idx] = (m_ctr[idx] + 1 > 3) ? 3 : m_ctr[idx] + 1;
        m_tgt[idx] = tgt;
      end else begin
        m_ctr[idx] = (m_ctr[idx] - 1 < 0) ? 0 : m_ctr[idx] - 1;
      end
    end else if (tk) begin
      slot = -1;
      for (int i = N - 1; i >= 0; i--) if (!m_valid[i]) slot = i;
      if (slot < 0) begin
        slot  = m_ptr;
        m_ptr = (m_ptr + 1) % N;
      end
      m_valid[slot] = 1'b1;
      m_tag[slot]   = pc[31:2];
      m_tgt[slot]   = tgt;
      m_ctr[slot]   = 2;
    end
  endfunction

  // Called just after a rising edge: drive, predict this cycle's lookup, advance the model.
  task automatic cyc(input bit rst, input bit uv, input logic [31:0] upc, input bit utk,
                     input logic [31:0] utgt, input bit fl, input logic [31:0] lpc);
    exp_t e;
    int   idx;
    reset            = rst;
    update_valid_in  = uv;
    update_pc_in     = upc;
    update_taken_in  = utk;
    update_target_in = utgt;
    flush_in         = fl;
    lookup_pc_in     = lpc;
    idx     = m_find(lpc);
    e.hit   = (idx >= 0);
    e.taken = (idx >= 0) ? (m_ctr[idx] >= 2) : 1'b0;
    e.tgt   = (idx >= 0) ? m_tgt[idx] : 32'h0;
    e.pc    = lpc;
    e.step  = 16'(step);
    q.push_back(e);
    step++;
    if (rst || fl) m_clear();
    else if (uv) m_update(upc, utk, utgt);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] lpc);
    cyc(0, 0, 32'h0, 0, 32'h0, 0, lpc);
  endtask

  task automatic upd(input logic [31:0] upc, input bit tk, input logic [31:0] tgt, input logic [31:0] lpc);
    cyc(0, 1, upc, tk, tgt, 0, lpc);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL no_expectation t=%0t", $time);
      end else begin
        e = q.pop_front();
        total++;
        if (hit_out !== e.hit) begin
          bad++;
          $display("FAIL hit step=%0d pc=%h got=%b want=%b", e.step, e.pc, hit_out, e.hit);
        end
        total++;
        if (predict_taken_out !== e.taken) begin
          bad++;
          $display("FAIL taken step=%0d pc=%h got=%b want=%b", e.step, e.pc, predict_taken_out, e.taken);
        end
        total++;
        if (predict_target_out !== e.tgt) begin
          bad++;
          $display("FAIL target step=%0d pc=%h got=%h want=%h", e.step, e.pc, predict_target_out, e.tgt);
        end
      end
    end
  end

  logic [31:0] pool[8];

  initial begin
    reset = 1'b1;
    update_valid_in = 1'b0;
    update_pc_in = '0;
    update_taken_in = 1'b0;
    update_target_in = '0;
    flush_in = 1'b0;
    lookup_pc_in = 32'h100;
    m_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    started = 1'b1;

    idle(32'h100);
    upd(32'h100, 1, 32'h200, 32'h100);
    idle(32'h100);
    idle(32'h102);
    for (int k = 0; k < 3; k++) upd(32'h100, 0, 32'h0, 32'h100);
    idle(32'h100);
    for (int k = 0; k < 2; k++) upd(32'h100, 1, 32'h200, 32'h100);
    idle(32'h101);

    cyc(0, 0, 32'h0, 0, 32'h0, 1, 32'h100);
    idle(32'h100);
    for (int k = 1; k <= 4; k++) upd(32'(k * 16), 1, 32'h1000 + 32'(k), 32'(k * 16));
    for (int k = 1; k <= 4; k++) idle(32'(k * 16));
    upd(32'h50, 1, 32'h1005, 32'h50);
    idle(32'h10);
    idle(32'h50);
    upd(32'h60, 1, 32'h1006, 32'h20);
    idle(32'h20);
    idle(32'h30);
    idle(32'h60);
    upd(32'h70, 1, 32'h1007, 32'h30);
    idle(32'h30);
    idle(32'h40);

    cyc(0, 1, 32'h300, 1, 32'h3000, 1, 32'h300);
    idle(32'h300);
    idle(32'h40);
    idle(32'h50);
    idle(32'h70);
    upd(32'h500, 1, 32'h5000, 32'h500);
    idle(32'h500);

    upd(32'h400, 1, 32'h404, 32'h400);
    idle(32'h400);

    cyc(1, 1, 32'h600, 1, 32'h6000, 0, 32'h400);
    idle(32'h600);
    idle(32'h400);

    for (int k = 0; k < 8; k++) pool[k] = 32'h8000 + 32'(k * 32'h40);
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] upc;
      logic [31:0] lpc;
      int r;
      upc = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
      lpc = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
      r = $urandom_range(0, 199);
      cyc(r == 0, $urandom_range(0, 3) != 0, upc, $urandom_range(0, 2) != 0,
          $urandom, r == 1 || r == 2, lpc);
    end

    started = 1'b0;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL leftover_expectations got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Multi-entry branch predictor for the fetch stage. It replaces the single-entry "last taken jump" register pair.
- Fully associative table of NUM_ENTRIES entries. Each entry holds a tag (branch PC), a target and a 2-bit saturating counter.
- Fetch queries it combinationally with the current PC each cycle. Execute updates it once per resolved control-flow instruction.

Parameters:
- XLEN, 32: PC/target width.
- NUM_ENTRIES, 4: table depth; power of two, >= 2.
- CTR_INIT, 2'b10: counter value written on allocation (weakly taken).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- lookup_pc_in  in  XLEN  PC currently being fetched
- hit_out  out  1  lookup_pc_in matches a valid entry
- predict_taken_out  out  1  hit_out and matching counter[1]==1
- predict_target_out  out  XLEN  target of matching entry; 0 on miss
- update_valid_in  in  1  execute resolved a branch/jump this cycle
- update_pc_in  in  XLEN  PC of resolved instruction
- update_taken_in  in  1  resolved direction
- update_target_in  in  XLEN  resolved target (valid when taken)
- flush_in  in  1  invalidate every entry (e.g. fence.i/exception)

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset. During reset: all valid bits 0, replacement pointer 0. Tag/target/counter contents are don't-care.
- Tag compare uses bits [XLEN-1:2] only; bits [1:0] are ignored.
- Lookup is purely combinational, zero-cycle latency.
  - Miss: hit_out=0, predict_taken_out=0, predict_target_out=0.
  - Multiple matching entries cannot occur, because allocation checks for a hit first. Priority falls to the lowest index anyway.
- Outputs after reset, with any lookup_pc_in: hit_out=0, predict_taken_out=0, predict_target_out=0.
- Update, registered on the clk edge when update_valid_in=1 and flush_in=0.
  - Hit, taken: counter = min(ctr+1, 3); target overwritten with update_target_in.
  - Hit, not taken: counter = max(ctr-1, 0); target unchanged. The entry stays valid even at counter 0.
  - Miss, taken: allocate. Write tag, target, valid=1, counter=CTR_INIT.
  - Miss, not taken: no state change.
- Allocation victim:
  - If any entry is invalid, use the lowest-index invalid entry; the pointer is unchanged.
  - Otherwise use the entry at the round-robin pointer, then pointer = (pointer+1) mod NUM_ENTRIES.
- Flush:
  - flush_in=1 clears all valid bits and the pointer at the next edge.
  - It takes priority over a simultaneous update; that update is dropped.
- Same-cycle lookup and update of the same PC: the lookup sees pre-update state. There is no bypass.
- No stall input. The updater guarantees one update per resolved instruction; repeats are applied again, and saturation keeps them benign.
- Reset asserted mid-operation overrides both update and flush.
- Expected size: about 150-250 lines of RTL.

Test Plan:
- Reset, then lookup 0x100 -> hit_out=0, predict_taken_out=0, predict_target_out=0.
- Update pc=0x100, taken, target=0x200; next cycle lookup 0x100 -> hit=1, taken=1 (ctr=2), target=0x200. Lookup 0x102 also hits (bits [1:0] ignored).
- Three not-taken updates at 0x100 -> ctr 2→1→0→0 (saturates at 0); predict_taken=0 and hit=1 after the first. Two taken updates -> ctr=2, predict_taken=1.
- Allocate taken branches at 0x10, 0x20, 0x30, 0x40 (fills 4 entries, pointer stays 0). Allocate 0x50 -> 0x10 evicted (entry 0), pointer=1. Allocate 0x60 -> 0x20 evicted, pointer=2.
- update_valid_in=1 (new pc=0x300, taken) with flush_in=1 in the same cycle -> next cycle lookups of 0x300 and all earlier PCs miss; next allocation lands in entry 0.
- Lookup 0x400 while updating 0x400 taken in the same cycle -> that cycle hit_out=0; following cycle hit_out=1 with the new target.
